// File: rtl/bias_group_sequencer_pkg.sv
// Shared definitions for the bias group sequencer: data width, FSM states,
// saturation bounds and the helper that locates a lane inside a flat bus.
package bias_group_sequencer_pkg;

  localparam int DW = 18;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  // Bit offset of lane 'lane' of bank 'bank' in a bus of banks that are
  // 'lanesPerBank' lanes wide; bank 0 doubles as the offset into a beat.
  function automatic int laneOffset(input int bank, input int lane, input int lanesPerBank);
    return DW * (bank * lanesPerBank + lane);
  endfunction

endpackage

// File: rtl/bias_group_sequencer_sat_lane.sv
// One lane of the bias adder: sign-extended add, clamp to the signed range
// of DW bits. Optional macro BIAS_SEQ_RELU_EN clamps negative results to 0.
module bias_sat_lane
  import bias_group_sequencer_pkg::*;
(
  input  logic [DW-1:0] lane_i,
  input  logic [DW-1:0] bias_i,
  output logic [DW-1:0] res_o
);

  logic [DW:0]   sum;
  logic [DW-1:0] sat;

  // Add one guard bit wide; a disagreement between the two top bits means the
  // true result left the DW-bit range, and the guard bit gives the direction.
  always_comb begin
    sum = {lane_i[DW-1], lane_i} + {bias_i[DW-1], bias_i};
    if (sum[DW] != sum[DW-1]) begin
      sat = sum[DW] ? SAT_MIN : SAT_MAX;
    end else begin
      sat = sum[DW-1:0];
    end
`ifdef BIAS_SEQ_RELU_EN
    res_o = sat[DW-1] ? '0 : sat;
`else
    res_o = sat;
`endif
  end

endmodule

// File: rtl/bias_group_sequencer.sv
// Bias group sequencer: adds one of N_GROUPS bias banks to each adder-tree
// beat, stepping to the next bank every PIX_PER_GROUP accepted beats, and
// signals done when the final beat of the pass leaves the output register.
// Optional macro BIAS_SEQ_RELU_EN (in bias_sat_lane) adds a ReLU after saturation.
module bias_group_sequencer
  import bias_group_sequencer_pkg::*;
#(
  parameter int N_adder_tree  = 16,
  parameter int N_GROUPS      = 4,
  parameter int PIX_PER_GROUP = 49,
  localparam int GW = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [N_GROUPS*N_adder_tree*DW-1:0]  bias_bus,
  input  logic [N_adder_tree*DW-1:0]           in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [N_adder_tree*DW-1:0]           out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [GW-1:0]                        grp_idx,
  output logic                                 busy,
  output logic                                 done
);

  localparam int            PW       = (PIX_PER_GROUP > 1) ? $clog2(PIX_PER_GROUP) : 1;
  localparam int            LW       = N_adder_tree * DW;
  localparam logic [PW-1:0] PIX_LAST = PW'(PIX_PER_GROUP - 1);
  localparam logic [GW-1:0] GRP_LAST = GW'(N_GROUPS - 1);

  seq_state_t    state_q;
  logic [PW-1:0] pixCnt_q, pixCnt_d;
  logic [GW-1:0] grpIdx_q, grpIdx_d;
  logic          outValid_q;
  logic [LW-1:0] outData_q, outData_d;
  logic          accept;
  logic          lastBeat;

  logic [DW-1:0] bankLane [N_GROUPS][N_adder_tree];

  // Unpack the flat bias bus into [bank][lane] so the bank mux is a plain index.
  for (genvar g = 0; g < N_GROUPS; g++) begin : gBank
    for (genvar i = 0; i < N_adder_tree; i++) begin : gLane
      assign bankLane[g][i] = bias_bus[laneOffset(g, i, N_adder_tree) +: DW];
    end
  end

  // One saturating adder per lane, fed from the bank selected by the current
  // (pre-increment) group index.
  for (genvar i = 0; i < N_adder_tree; i++) begin : gAdd
    bias_sat_lane uLane (
      .lane_i (in_data  [laneOffset(0, i, N_adder_tree) +: DW]),
      .bias_i (bankLane[grpIdx_q][i]),
      .res_o  (outData_d[laneOffset(0, i, N_adder_tree) +: DW])
    );
  end

  assign in_ready  = (state_q == RUN) && (!outValid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign grp_idx   = grpIdx_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DRAIN) && outValid_q && out_ready;

  // Pixel/group counters advance only on accepted beats; the last pixel of
  // the last group marks the final beat of the pass.
  always_comb begin
    pixCnt_d = pixCnt_q;
    grpIdx_d = grpIdx_q;
    lastBeat = 1'b0;
    if (accept) begin
      if (pixCnt_q == PIX_LAST) begin
        pixCnt_d = '0;
        if (grpIdx_q == GRP_LAST) begin
          grpIdx_d = '0;
          lastBeat = 1'b1;
        end else begin
          grpIdx_d = grpIdx_q + GW'(1);
        end
      end else begin
        pixCnt_d = pixCnt_q + PW'(1);
      end
    end
  end

  // Pass FSM plus the output register; a new beat may load in the same cycle
  // the old one is taken, so a full-rate stream never bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pixCnt_q   <= '0;
      grpIdx_q   <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
    end else begin
      pixCnt_q <= pixCnt_d;
      grpIdx_q <= grpIdx_d;
      if (accept) begin
        outData_q  <= outData_d;
        outValid_q <= 1'b1;
      end else if (out_ready) begin
        outValid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= RUN;
            pixCnt_q <= '0;
            grpIdx_q <= '0;
          end
        end
        RUN: begin
          if (lastBeat) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (outValid_q && out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
